// File: rtl/mc_ctrl_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mc_ctrl_fsm_pkg                                        |
// | Description : Shared constants for the multi-cycle MIPS32 control    |
// |               unit: state encodings, opcode/func values, ALU codes,  |
// |               datapath mux-select encodings and func decode helpers. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_EXE_BR   = 4'd4,
    S_EXE_ADDR = 4'd5,
    S_EXE_J    = 4'd6,
    S_MEM_LW   = 4'd7,
    S_MEM_SW   = 4'd8,
    S_WB_R     = 4'd9,
    S_WB_I     = 4'd10,
    S_WB_LW    = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;

  // Mux-select encodings
  localparam logic [2:0] SRCB_B      = 3'd0;
  localparam logic [2:0] SRCB_4      = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH = 3'd3;
  localparam logic [2:0] SRCB_ZIMM   = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] RDST_RT  = 2'd0;
  localparam logic [1:0] RDST_RD  = 2'd1;
  localparam logic [1:0] RDST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  function automatic logic func_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND,
      FN_OR, FN_XOR, FN_NOR, FN_SLT: func_legal = 1'b1;
      default:                       func_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] func_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  func_alu_op = ALU_SUB;
      FN_AND:  func_alu_op = ALU_AND;
      FN_OR:   func_alu_op = ALU_OR;
      FN_XOR:  func_alu_op = ALU_XOR;
      FN_NOR:  func_alu_op = ALU_NOR;
      FN_SLT:  func_alu_op = ALU_SLT;
      FN_SLL:  func_alu_op = ALU_SLL;
      FN_SRL:  func_alu_op = ALU_SRL;
      default: func_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mc_wait_timer                                          |
// | Description : Counts stalled cycles while a memory state waits for   |
// |               mem_ready; clears whenever the wait ends or the FSM is |
// |               elsewhere, and flags expiry at the all-ones count.     |
// | Ports       : clk, nrst   - clock, async active-low reset            |
// |               active      - FSM is in a memory-waiting state         |
// |               ready       - effective memory ready this cycle        |
// |               expire      - wait budget exhausted this cycle         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mc_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam logic [WAIT_W-1:0] C_MAX = '1;

  logic [WAIT_W-1:0] r_cnt;

  // A ready in the final cycle still wins, so expiry requires ready low.
  assign expire = active && !ready && (r_cnt == C_MAX);

  // Leaving the state (ready, expiry, or not a wait state) clears the count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (active && !ready && !expire) begin
      r_cnt <= r_cnt + WAIT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mc_ctrl_fsm                                            |
// | Description : Multi-cycle MIPS32 control unit. Moore FSM decoding    |
// |               op/func into datapath enables and mux selects, with a  |
// |               memory ready handshake, wait timeout, illegal-op trap  |
// |               and a retired-instruction counter.                     |
// | Ports       : op/func/zero/mem_ready in; datapath enables, selects,  |
// |               alu_op, state, instr_done, trap, timeout, retired out. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int OP_W              = 6,
  parameter int FUNC_W            = 6,
  parameter int ALUOP_W           = 4,
  parameter int USE_MEM_HANDSHAKE = 1,
  parameter int WAIT_W            = 4,
  parameter int CNT_W             = 32
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               mdr_write,
  output logic               reg_write,
  output logic               a_write,
  output logic               b_write,
  output logic               alu_out_write,
  output logic               pc_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               trap,
  output logic               timeout,
  output logic [CNT_W-1:0]   retired
);

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_wait_active;
  logic             w_expire;
  logic [3:0]       w_alu;
  logic [5:0]       w_op;
  logic [5:0]       w_fn;
  logic             r_timeout;
  logic [CNT_W-1:0] r_retired;

  assign w_op = 6'(op);
  assign w_fn = 6'(func);

  generate
    if (USE_MEM_HANDSHAKE != 0) begin : g_handshake
      assign w_ready = mem_ready;
    end else begin : g_no_handshake
      assign w_ready = 1'b1;
    end
  endgenerate

  assign w_wait_active = (r_state == S_IF) || (r_state == S_MEM_LW) ||
                         (r_state == S_MEM_SW);

  mc_wait_timer #(
    .WAIT_W (WAIT_W)
  ) u_wait_timer (
    .clk    (clk),
    .nrst   (nrst),
    .active (w_wait_active),
    .ready  (w_ready),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    a_write       = 1'b0;
    b_write       = 1'b0;
    alu_out_write = 1'b0;
    pc_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    w_alu         = ALU_ADD;
    pc_src        = PCSRC_ALU;
    reg_dst       = RDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    instr_done    = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = w_ready;
        pc_write  = w_ready;
        if (w_expire)     w_next = S_TRAP;
        else if (w_ready) w_next = S_ID;
      end
      S_ID: begin
        // Branch target is precomputed into ALUOut while decoding.
        a_write       = 1'b1;
        b_write       = 1'b1;
        alu_out_write = 1'b1;
        alu_src_b     = SRCB_IMM_SH;
        case (w_op)
          OP_RTYPE:                                   w_next = func_legal(w_fn) ? S_EXE_R : S_TRAP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_EXE_I;
          OP_BEQ, OP_BNE:                             w_next = S_EXE_BR;
          OP_LW, OP_SW:                               w_next = S_EXE_ADDR;
          OP_J, OP_JAL:                               w_next = S_EXE_J;
          default:                                    w_next = S_TRAP;
        endcase
      end
      S_EXE_R: begin
        alu_src_a     = 1'b1;
        alu_out_write = 1'b1;
        w_alu         = func_alu_op(w_fn);
        w_next        = S_WB_R;
      end
      S_EXE_I: begin
        alu_src_a     = 1'b1;
        alu_out_write = 1'b1;
        alu_src_b     = SRCB_IMM;
        case (w_op)
          OP_SLTI: w_alu = ALU_SLT;
          OP_ANDI: begin alu_src_b = SRCB_ZIMM; w_alu = ALU_AND; end
          OP_ORI:  begin alu_src_b = SRCB_ZIMM; w_alu = ALU_OR;  end
          OP_XORI: begin alu_src_b = SRCB_ZIMM; w_alu = ALU_XOR; end
          default: w_alu = ALU_ADD;
        endcase
        w_next = S_WB_I;
      end
      S_EXE_BR: begin
        alu_src_a  = 1'b1;
        w_alu      = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = (w_op == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        w_next     = S_IF;
      end
      S_EXE_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_out_write = 1'b1;
        w_next        = (w_op == OP_SW) ? S_MEM_SW : S_MEM_LW;
      end
      S_EXE_J: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        // PC was already advanced in IF, so it is the link value.
        if (w_op == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = RDST_R31;
          mem_to_reg = M2R_PC;
        end
        instr_done = 1'b1;
        w_next     = S_IF;
      end
      S_MEM_LW: begin
        iord      = 1'b1;
        mem_read  = 1'b1;
        mdr_write = w_ready;
        if (w_expire)     w_next = S_TRAP;
        else if (w_ready) w_next = S_WB_LW;
      end
      S_MEM_SW: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = w_ready;
        if (w_expire)     w_next = S_TRAP;
        else if (w_ready) w_next = S_IF;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RD;
        instr_done = 1'b1;
        w_next     = S_IF;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_IF;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
        w_next     = S_IF;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_expire)   r_timeout <= 1'b1;
      if (instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign alu_op  = ALUOP_W'(w_alu);
  assign state   = r_state;
  assign trap    = (r_state == S_TRAP);
  assign timeout = r_timeout;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mc_ctrl_fsm                                         |
// | Description : Self-checking bench for mc_ctrl_fsm: decode table,     |
// |               hand-written multi-cycle sequences and randomized      |
// |               instruction streams against a sequence-level model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        nrst;
  logic [5:0]  op, func;
  logic        zero, mem_ready;
  logic        ir_write, mdr_write, reg_write, a_write, b_write;
  logic        alu_out_write, pc_write, mem_read, mem_write, iord, alu_src_a;
  logic [2:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic [1:0]  pc_src, reg_dst, mem_to_reg;
  logic [3:0]  state;
  logic        instr_done, trap, timeout;
  logic [31:0] retired;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .OP_W(6), .FUNC_W(6), .ALUOP_W(4), .USE_MEM_HANDSHAKE(1), .WAIT_W(4), .CNT_W(32)
  ) dut (
    .clk(clk), .nrst(nrst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .mdr_write(mdr_write), .reg_write(reg_write),
    .a_write(a_write), .b_write(b_write), .alu_out_write(alu_out_write),
    .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .instr_done(instr_done), .trap(trap), .timeout(timeout), .retired(retired)
  );

  // ALU code expectations: ADD0 SUB1 AND2 OR3 XOR4 NOR5 SLT6 SLL7 SRL8.
  typedef struct {
    logic [5:0] op;  logic [5:0] fn;  logic z;
    logic [3:0] st;  logic sa;  logic [2:0] sb;  logic [3:0] alu;
    logic pw;  logic [1:0] ps;  logic rw;  logic [1:0] rd;  logic [1:0] m2r;
    logic aow;  logic done;
  } vec_t;

  typedef struct {
    logic [3:0] st; logic rdy; logic done; logic regw;
  } step_t;

  vec_t  vt[$];
  step_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    mem_ready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  function automatic step_t mk(input logic [3:0] st, input logic rdy,
                               input logic done, input logic regw);
    step_t s;
    s.st = st; s.rdy = rdy; s.done = done; s.regw = regw;
    return s;
  endfunction

  logic [5:0]  legal_fn [9];
  logic [5:0]  ill_op   [4];
  logic [5:0]  imm_op   [5];
  logic [31:0] exp_ret;
  int          cat, nst;
  logic        ill;

  initial begin
    nrst = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
    ill_op   = '{6'h3F, 6'h01, 6'h09, 6'h20};
    imm_op   = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

    //              op    fn    z   st sa sb alu pw ps rw rd m2r aow done
    vt.push_back('{6'h00, 6'h20, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h22, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h24, 0, 2, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h25, 0, 2, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h26, 0, 2, 1, 0, 4, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h27, 0, 2, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h2A, 0, 2, 1, 0, 6, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h00, 0, 2, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h00, 6'h02, 0, 2, 1, 0, 8, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h08, 6'h11, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h0A, 6'h11, 0, 3, 1, 2, 6, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h0C, 6'h11, 0, 3, 1, 4, 2, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h0D, 6'h11, 0, 3, 1, 4, 3, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h0E, 6'h11, 0, 3, 1, 4, 4, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h04, 6'h00, 1, 4, 1, 0, 1, 1, 1, 0, 0, 0, 0, 1});
    vt.push_back('{6'h04, 6'h00, 0, 4, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1});
    vt.push_back('{6'h05, 6'h00, 1, 4, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1});
    vt.push_back('{6'h05, 6'h00, 0, 4, 1, 0, 1, 1, 1, 0, 0, 0, 0, 1});
    vt.push_back('{6'h23, 6'h00, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h2B, 6'h00, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{6'h02, 6'h00, 0, 6, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1});
    vt.push_back('{6'h03, 6'h00, 0, 6, 0, 0, 0, 1, 2, 1, 2, 2, 0, 1});

    // ---- reset state and IF/ID decode -------------------------------
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_trap", trap, 0);
    chk("rst_timeout", timeout, 0);
    op = 6'h00; func = 6'h20; mem_ready = 1'b0; #1;
    chk("if_irw_stall", ir_write, 0);
    chk("if_pcw_stall", pc_write, 0);
    chk("if_memrd", mem_read, 1);
    chk("if_srcb", alu_src_b, 1);
    mem_ready = 1'b1; #1;
    chk("if_irw_ready", ir_write, 1);
    tick();
    chk("id_state", state, 1);
    chk("id_enables", {a_write, b_write, alu_out_write}, 3'b111);
    chk("id_srcb", alu_src_b, 3);
    tick();
    chk("add_exe", state, 2);
    tick();
    chk("add_wb", state, 9);
    chk("add_wb_rw_rd", {reg_write, reg_dst}, 3'b101);
    chk("add_wb_done", instr_done, 1);
    tick();
    chk("add_ret", retired, 1);
    chk("add_back_if", state, 0);

    // ---- illegal op keeps retired -----------------------------------
    op = 6'h3F; tick(); tick();
    chk("illop_state", state, 15);
    chk("illop_trap", trap, 1);
    chk("illop_ret", retired, 1);
    chk("illop_en", {ir_write, mdr_write, reg_write, a_write, b_write,
                     alu_out_write, pc_write, mem_read, mem_write}, 0);
    tick();
    chk("illop_ret_hold", retired, 1);

    do_reset();
    op = 6'h00; func = 6'h3F; mem_ready = 1'b1; tick(); tick();
    chk("illfn_state", state, 15);
    chk("illfn_ret", retired, 0);

    // ---- decode table -----------------------------------------------
    for (int i = 0; i < vt.size(); i++) begin
      do_reset();
      op = vt[i].op; func = vt[i].fn; zero = vt[i].z; mem_ready = 1'b1;
      tick(); tick();
      chk($sformatf("v%0d_state", i), state, vt[i].st);
      chk($sformatf("v%0d_srca", i), alu_src_a, vt[i].sa);
      chk($sformatf("v%0d_srcb", i), alu_src_b, vt[i].sb);
      chk($sformatf("v%0d_alu", i), alu_op, vt[i].alu);
      chk($sformatf("v%0d_pcw", i), pc_write, vt[i].pw);
      chk($sformatf("v%0d_pcsrc", i), pc_src, vt[i].ps);
      chk($sformatf("v%0d_regw", i), reg_write, vt[i].rw);
      chk($sformatf("v%0d_regdst", i), reg_dst, vt[i].rd);
      chk($sformatf("v%0d_m2r", i), mem_to_reg, vt[i].m2r);
      chk($sformatf("v%0d_aow", i), alu_out_write, vt[i].aow);
      chk($sformatf("v%0d_done", i), instr_done, vt[i].done);
    end

    // ---- LW with three stalled cycles in MEM_LW ---------------------
    do_reset();
    op = 6'h23; mem_ready = 1'b1; tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3); #1;
      chk($sformatf("lw_mem_state%0d", k), state, 7);
      chk($sformatf("lw_mdrw%0d", k), mdr_write, (k == 3));
      chk($sformatf("lw_iord%0d", k), {iord, mem_read}, 2'b11);
      tick();
    end
    chk("lw_wb_state", state, 11);
    chk("lw_wb_m2r", {reg_write, mem_to_reg}, 3'b101);
    tick();
    chk("lw_ret", retired, 1);

    // ---- JAL is three cycles ----------------------------------------
    do_reset();
    op = 6'h03; mem_ready = 1'b1; tick(); tick(); tick();
    chk("jal_3cyc_state", state, 0);
    chk("jal_ret", retired, 1);

    // ---- IF timeout -------------------------------------------------
    do_reset();
    for (int k = 0; k < 16; k++) begin
      mem_ready = 1'b0; #1;
      chk($sformatf("to_wait%0d", k), state, 0);
      tick();
    end
    chk("to_state", state, 15);
    chk("to_timeout", timeout, 1);
    chk("to_trap", trap, 1);
    chk("to_en", {ir_write, mdr_write, reg_write, a_write, b_write,
                  alu_out_write, pc_write, mem_read, mem_write}, 0);
    mem_ready = 1'b1; tick(); tick();
    chk("to_hold", state, 15);
    do_reset();
    chk("to_clr", {state, trap, timeout}, 0);

    // ---- ready arriving at the last count wins ----------------------
    mem_ready = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1; #1;
    chk("win_state", state, 0);
    chk("win_irw", ir_write, 1);
    tick();
    chk("win_id", state, 1);
    chk("win_timeout", timeout, 0);

    // ---- reset in the middle of write-back --------------------------
    do_reset();
    op = 6'h00; func = 6'h20; mem_ready = 1'b1; tick(); tick(); tick();
    chk("mid_wb", state, 9);
    nrst = 1'b0; #1;
    chk("mid_state", state, 0);
    chk("mid_regw", reg_write, 0);
    @(posedge clk); #1;
    chk("mid_ret", retired, 0);
    nrst = 1'b1;

    // ---- randomized instruction stream vs sequence model ------------
    do_reset();
    exp_ret = 0;
    for (int n = 0; n < 200; n++) begin
      q.delete();
      ill = 1'b0;
      cat = $urandom_range(0, 7);
      zero = 1'($urandom);
      func = 6'($urandom);
      nst = $urandom_range(0, 4);
      for (int s = 0; s < nst; s++) q.push_back(mk(0, 0, 0, 0));
      q.push_back(mk(0, 1, 0, 0));
      q.push_back(mk(1, 1'($urandom), 0, 0));
      case (cat)
        0: begin
          op = 6'h00; func = legal_fn[$urandom_range(0, 8)];
          q.push_back(mk(2, 1'($urandom), 0, 0));
          q.push_back(mk(9, 1'($urandom), 1, 1));
        end
        1: begin
          op = imm_op[$urandom_range(0, 4)];
          q.push_back(mk(3, 1'($urandom), 0, 0));
          q.push_back(mk(10, 1'($urandom), 1, 1));
        end
        2: begin
          op = ($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04;
          q.push_back(mk(4, 1'($urandom), 1, 0));
        end
        3, 4: begin
          op = (cat == 3) ? 6'h23 : 6'h2B;
          q.push_back(mk(5, 1'($urandom), 0, 0));
          nst = $urandom_range(0, 6);
          for (int s = 0; s < nst; s++) q.push_back(mk((cat == 3) ? 4'd7 : 4'd8, 0, 0, 0));
          q.push_back(mk((cat == 3) ? 4'd7 : 4'd8, 1, (cat == 4), 0));
          if (cat == 3) q.push_back(mk(11, 1'($urandom), 1, 1));
        end
        5: begin
          op = ($urandom_range(0, 1) != 0) ? 6'h03 : 6'h02;
          q.push_back(mk(6, 1'($urandom), 1, (op == 6'h03)));
        end
        6: begin
          op = ill_op[$urandom_range(0, 3)]; ill = 1'b1;
        end
        default: begin
          op = 6'h00; func = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h21; ill = 1'b1;
        end
      endcase
      foreach (q[i]) begin
        mem_ready = q[i].rdy; #1;
        chk($sformatf("r%0d_st%0d", n, i), state, q[i].st);
        chk($sformatf("r%0d_done%0d", n, i), instr_done, q[i].done);
        chk($sformatf("r%0d_regw%0d", n, i), reg_write, q[i].regw);
        if (q[i].done) exp_ret = exp_ret + 1;
        tick();
      end
      chk($sformatf("r%0d_ret", n), retired, exp_ret);
      if (ill) begin
        chk($sformatf("r%0d_trap", n), {state, trap}, {4'd15, 1'b1});
        do_reset();
        exp_ret = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
